// File: rtl/redstone_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | redstone_pkg: opcodes and default pulse lengths for the input driver |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package redstone_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP          = 3'd0;
    localparam logic [OP_W-1:0] OP_LEVER_ON     = 3'd1;
    localparam logic [OP_W-1:0] OP_LEVER_OFF    = 3'd2;
    localparam logic [OP_W-1:0] OP_LEVER_TOGGLE = 3'd3;
    localparam logic [OP_W-1:0] OP_PRESS_STONE  = 3'd4;
    localparam logic [OP_W-1:0] OP_PRESS_WOOD   = 3'd5;
    localparam logic [OP_W-1:0] OP_CLEAR_ALL    = 3'd6;
    localparam logic [OP_W-1:0] OP_RESERVED     = 3'd7;

    localparam int STONE_TICKS_DEF = 10;
    localparam int WOOD_TICKS_DEF  = 15;

    // Opcodes whose index must name a real channel.
    function automatic logic op_uses_idx(input logic [OP_W-1:0] op);
        return (op >= OP_LEVER_ON) && (op <= OP_PRESS_WOOD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/redstone_input_driver_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | input_cmd_fifo: synchronous command FIFO with occupancy count        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module input_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_depth);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    // A full FIFO refuses a push even if it is popped this cycle.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/redstone_input_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | redstone_input_driver: queues host lever/button commands and applies |
// | one per redstone tick onto a registered input vector. Rev 1.0        |
// +----------------------------------------------------------------------+
module redstone_input_driver
    import redstone_pkg::*;
#(
    parameter int N_INPUTS    = 8,
    parameter int IDX_W       = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1,
    parameter int DEPTH       = 4,
    parameter int STONE_TICKS = STONE_TICKS_DEF,
    parameter int WOOD_TICKS  = WOOD_TICKS_DEF,
    parameter int CNT_W       = 5
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_tick,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [IDX_W-1:0]         i_cmd_idx,
    input  logic [2:0]               i_cmd_op,
    output logic [N_INPUTS-1:0]      o_inputs,
    output logic                     o_cmd_err,
    output logic [$clog2(DEPTH):0]   o_fifo_count
);

    localparam int FW = IDX_W + OP_W;
    localparam logic [CNT_W-1:0] c_stone_ticks = CNT_W'(STONE_TICKS);
    localparam logic [CNT_W-1:0] c_wood_ticks  = CNT_W'(WOOD_TICKS);

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [FW-1:0]         w_head;
    logic [IDX_W-1:0]      w_head_idx;
    logic [OP_W-1:0]       w_head_op;
    logic [31:0]           w_head_idx_ext;
    logic                  w_idx_ok;
    logic                  w_bad;
    logic                  w_apply;

    logic [N_INPUTS-1:0]   r_lever;
    logic [CNT_W-1:0]      r_cnt [N_INPUTS];
    logic [N_INPUTS-1:0]   w_lever_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt [N_INPUTS];
    logic [N_INPUTS-1:0]   w_out_nxt;
    logic [N_INPUTS-1:0]   r_inputs;
    logic                  r_err;

    assign o_cmd_ready = !w_full && i_rst_n;
    assign w_push      = i_cmd_valid && o_cmd_ready;
    assign w_pop       = i_tick && !w_empty;

    input_cmd_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_data  ({i_cmd_idx, i_cmd_op}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (o_fifo_count)
    );

    assign w_head_idx     = w_head[FW-1:OP_W];
    assign w_head_op      = w_head[OP_W-1:0];
    assign w_head_idx_ext = {{(32-IDX_W){1'b0}}, w_head_idx};
    assign w_idx_ok       = (w_head_idx_ext < 32'(N_INPUTS));
    assign w_bad          = w_pop && ((w_head_op == OP_RESERVED) ||
                                      (op_uses_idx(w_head_op) && !w_idx_ok));
    assign w_apply        = w_pop && !w_bad;

    // Next channel state; a channel loaded this tick is not also decremented.
    always_comb begin
        w_lever_nxt = r_lever;
        for (int i = 0; i < N_INPUTS; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
        end
        if (i_tick) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                if (r_cnt[i] != '0) begin
                    w_cnt_nxt[i] = r_cnt[i] - 1'b1;
                end
                if (w_apply && (w_head_idx_ext == 32'(i))) begin
                    case (w_head_op)
                        OP_LEVER_ON:     w_lever_nxt[i] = 1'b1;
                        OP_LEVER_OFF:    w_lever_nxt[i] = 1'b0;
                        OP_LEVER_TOGGLE: w_lever_nxt[i] = !r_lever[i];
                        OP_PRESS_STONE: begin
                            if (r_cnt[i] == '0) begin
                                w_cnt_nxt[i] = c_stone_ticks;
                            end
                        end
                        OP_PRESS_WOOD: begin
                            if (r_cnt[i] == '0) begin
                                w_cnt_nxt[i] = c_wood_ticks;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            if (w_apply && (w_head_op == OP_CLEAR_ALL)) begin
                w_lever_nxt = '0;
                for (int i = 0; i < N_INPUTS; i++) begin
                    w_cnt_nxt[i] = '0;
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < N_INPUTS; g++) begin : g_chan_out
            assign w_out_nxt[g] = w_lever_nxt[g] | (w_cnt_nxt[g] != '0);
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_lever  <= '0;
            r_inputs <= '0;
            r_err    <= 1'b0;
            for (int i = 0; i < N_INPUTS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_lever <= w_lever_nxt;
            r_err   <= w_bad;
            for (int i = 0; i < N_INPUTS; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            if (i_tick) begin
                r_inputs <= w_out_nxt;
            end
        end
    end

    assign o_inputs  = r_inputs;
    assign o_cmd_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_redstone_input_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_redstone_input_driver: directed self-checking bench               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_redstone_input_driver;

    localparam logic [2:0] c_nop    = 3'd0;
    localparam logic [2:0] c_on     = 3'd1;
    localparam logic [2:0] c_off    = 3'd2;
    localparam logic [2:0] c_stone  = 3'd4;
    localparam logic [2:0] c_wood   = 3'd5;
    localparam logic [2:0] c_clear  = 3'd6;
    localparam logic [2:0] c_rsvd   = 3'd7;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_idx;
    logic [2:0] cmd_op;
    logic [7:0] inputs;
    logic       cmd_err;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;

    redstone_input_driver #(
        .N_INPUTS (8),
        .IDX_W    (4),
        .DEPTH    (4)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_tick       (tick),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_idx    (cmd_idx),
        .i_cmd_op     (cmd_op),
        .o_inputs     (inputs),
        .o_cmd_err    (cmd_err),
        .o_fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] idx, input logic [2:0] op);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_idx   = idx;
        cmd_op    = op;
        while (!cmd_ready && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL push_timeout: ready=%0b required 1", cmd_ready);
        end
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic clean();
        push(4'd0, c_clear);
        do_tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_low: got %0b required 0", cmd_ready);
        end
        rst_n = 1'b1;
        step();
        checks += 4;
        if (inputs !== 8'h00) begin
            errors++;
            $display("FAIL reset_inputs: got %h required 00", inputs);
        end
        if (cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got %0b required 0", cmd_err);
        end
        if (fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d required 0", fifo_count);
        end
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %0b required 1", cmd_ready);
        end
    endtask

    task automatic test_lever_on();
        push(4'd3, c_on);
        checks++;
        if (fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL lever_count_pre: got %0d required 1", fifo_count);
        end
        checks++;
        if (inputs !== 8'h00) begin
            errors++;
            $display("FAIL lever_no_tick: got %h required 00", inputs);
        end
        do_tick();
        checks += 2;
        if (inputs !== 8'h08) begin
            errors++;
            $display("FAIL lever_on: got %h required 08", inputs);
        end
        if (fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL lever_count_post: got %0d required 0", fifo_count);
        end
    endtask

    task automatic test_stone_pulse();
        clean();
        push(4'd0, c_stone);
        do_tick();
        checks++;
        if (inputs[0] !== 1'b1) begin
            errors++;
            $display("FAIL stone_t0: got %0b required 1", inputs[0]);
        end
        for (int k = 1; k <= 11; k++) begin
            if (k == 4) push(4'd0, c_stone);
            do_tick();
            checks += 2;
            if (inputs[0] !== (k <= 9)) begin
                errors++;
                $display("FAIL stone_t%0d: got %0b required %0b", k, inputs[0], (k <= 9));
            end
            if (cmd_err !== 1'b0) begin
                errors++;
                $display("FAIL stone_err_t%0d: got %0b required 0", k, cmd_err);
            end
        end
    endtask

    task automatic test_fifo_full();
        clean();
        push(4'd0, c_on);
        push(4'd1, c_on);
        push(4'd2, c_on);
        push(4'd5, c_on);
        checks += 2;
        if (fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL full_count: got %0d required 4", fifo_count);
        end
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: got %0b required 0", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_idx   = 4'd7;
        cmd_op    = c_on;
        step();
        checks++;
        if (fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL full_hold: got %0d required 4", fifo_count);
        end
        do_tick();
        checks += 3;
        if (fifo_count !== 3'd3) begin
            errors++;
            $display("FAIL full_pop_refuse: got %0d required 3", fifo_count);
        end
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_ready_back: got %0b required 1", cmd_ready);
        end
        if (inputs !== 8'h01) begin
            errors++;
            $display("FAIL full_first_apply: got %h required 01", inputs);
        end
        step();
        cmd_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL full_fifth_accept: got %0d required 4", fifo_count);
        end
        for (int k = 0; k < 4; k++) do_tick();
        checks += 2;
        if (inputs !== 8'hA7) begin
            errors++;
            $display("FAIL full_drain: got %h required a7", inputs);
        end
        if (fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL full_drain_count: got %0d required 0", fifo_count);
        end
    endtask

    task automatic test_wood_lever();
        clean();
        push(4'd2, c_wood);
        push(4'd2, c_on);
        for (int k = 1; k <= 16; k++) begin
            if (k == 5) push(4'd2, c_off);
            do_tick();
            checks++;
            if (inputs[2] !== (k <= 15)) begin
                errors++;
                $display("FAIL wood_t%0d: got %0b required %0b", k, inputs[2], (k <= 15));
            end
        end
    endtask

    task automatic test_errors();
        clean();
        push(4'd1, c_on);
        do_tick();
        push(4'd0, c_rsvd);
        checks++;
        if (cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL err_idle: got %0b required 0", cmd_err);
        end
        do_tick();
        checks += 2;
        if (cmd_err !== 1'b1) begin
            errors++;
            $display("FAIL err_op7: got %0b required 1", cmd_err);
        end
        if (inputs !== 8'h02) begin
            errors++;
            $display("FAIL err_op7_inputs: got %h required 02", inputs);
        end
        step();
        checks++;
        if (cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL err_op7_width: got %0b required 0", cmd_err);
        end
        push(4'd9, c_on);
        do_tick();
        checks += 2;
        if (cmd_err !== 1'b1) begin
            errors++;
            $display("FAIL err_idx9: got %0b required 1", cmd_err);
        end
        if (inputs !== 8'h02) begin
            errors++;
            $display("FAIL err_idx9_inputs: got %h required 02", inputs);
        end
        step();
        checks++;
        if (cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL err_idx9_width: got %0b required 0", cmd_err);
        end
        push(4'd0, c_nop);
        do_tick();
        checks++;
        if (cmd_err !== 1'b0 || inputs !== 8'h02) begin
            errors++;
            $display("FAIL nop: got err=%0b inputs=%h required err=0 inputs=02", cmd_err, inputs);
        end
    endtask

    task automatic test_clear_all();
        clean();
        push(4'd1, c_on);
        push(4'd4, c_on);
        push(4'd6, c_stone);
        do_tick();
        do_tick();
        do_tick();
        checks++;
        if (inputs !== 8'h52) begin
            errors++;
            $display("FAIL clear_setup: got %h required 52", inputs);
        end
        push(4'd3, c_clear);
        do_tick();
        checks++;
        if (inputs !== 8'h00) begin
            errors++;
            $display("FAIL clear_all: got %h required 00", inputs);
        end
        do_tick();
        checks++;
        if (inputs !== 8'h00) begin
            errors++;
            $display("FAIL clear_stays: got %h required 00", inputs);
        end
    endtask

    task automatic test_reset_mid();
        push(4'd6, c_stone);
        do_tick();
        push(4'd0, c_on);
        push(4'd1, c_on);
        push(4'd2, c_on);
        checks += 2;
        if (inputs !== 8'h40) begin
            errors++;
            $display("FAIL mid_setup: got %h required 40", inputs);
        end
        if (fifo_count !== 3'd3) begin
            errors++;
            $display("FAIL mid_count: got %0d required 3", fifo_count);
        end
        rst_n = 1'b0;
        step();
        checks += 2;
        if (fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL mid_rst_count: got %0d required 0", fifo_count);
        end
        if (inputs !== 8'h00) begin
            errors++;
            $display("FAIL mid_rst_inputs: got %h required 00", inputs);
        end
        rst_n = 1'b1;
        step();
        do_tick();
        checks++;
        if (inputs !== 8'h00 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL mid_after: got inputs=%h count=%0d required 00/0", inputs, fifo_count);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        tick      = 1'b0;
        cmd_valid = 1'b0;
        cmd_idx   = 4'd0;
        cmd_op    = 3'd0;
        test_reset();
        test_lever_on();
        test_stone_pulse();
        test_fifo_full();
        test_wood_lever();
        test_errors();
        test_clear_all();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
